// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad front end for the calculator operator.
// Validates keys against "[sign] digits(1-3) enter operator [sign] digits(1-3) enter",
// inserts implied signs/enters, and drives the operator with single-cycle strobes.
module calc_key_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic        op_sel,
  output logic [10:0] op_data,
  output logic        op_rst,
  output logic        result_valid,
  output logic        key_err
);

  typedef enum logic [2:0] {
    INIT, SIGN1, DIG1, OPER, SIGN2, DIG2, WAIT, RESULT
  } state_e;

  // Work queued for the following cycle while key_ready is low.
  typedef enum logic [1:0] {
    PEND_NONE,    // nothing queued
    PEND_FWD,     // strobe pend_code to the operator
    PEND_REPROC   // handle pend_code as a key arriving in SIGN1
  } pend_e;

  localparam logic [3:0] K_PLUS    = 4'd10;
  localparam logic [3:0] K_MINUS   = 4'd11;
  localparam logic [3:0] K_TIMES   = 4'd12;
  localparam logic [3:0] K_CLEAR   = 4'd13;
  localparam logic [3:0] K_ENTER   = 4'd14;
  localparam logic [3:0] K_ILLEGAL = 4'd15;

  state_e      state_q, state_d;
  pend_e       pend_q, pend_d;
  logic [3:0]  pend_code_q, pend_code_d;
  logic [1:0]  ndig_q, ndig_d;
  logic        key_ready_q, key_ready_d;
  logic        op_sel_q, op_sel_d;
  logic [3:0]  op_data_q, op_data_d;
  logic        op_rst_q, op_rst_d;
  logic        result_valid_q, result_valid_d;
  logic        key_err_q, key_err_d;

  logic        reproc, take, hold, is_dig, is_sign;
  logic [3:0]  code;

  // Next-state and next-output decode for the whole sequencer.
  always_comb begin
    state_d        = state_q;
    pend_d         = PEND_NONE;
    pend_code_d    = pend_code_q;
    ndig_d         = ndig_q;
    op_sel_d       = 1'b0;
    op_data_d      = op_data_q;
    op_rst_d       = 1'b0;
    result_valid_d = result_valid_q;
    key_err_d      = 1'b0;
    hold           = 1'b0;

    reproc  = (pend_q == PEND_REPROC);
    code    = reproc ? pend_code_q : key_code;
    take    = reproc || (key_valid && key_ready_q);
    is_dig  = (code <= 4'd9);
    is_sign = (code == K_PLUS) || (code == K_MINUS);

    if (state_q == INIT) begin
      op_rst_d       = 1'b1;
      result_valid_d = 1'b0;
      ndig_d         = '0;
      state_d        = SIGN1;
      hold           = 1'b1;
    end else if (pend_q == PEND_FWD) begin
      op_sel_d  = 1'b1;
      op_data_d = pend_code_q;
      if (pend_code_q == K_ENTER) state_d = WAIT;
    end else if (state_q == WAIT) begin
      // op_sel_q high means the final enter is on the wire this cycle;
      // the operator's registered result is only valid one cycle later.
      if (!op_sel_q) begin
        state_d        = RESULT;
        result_valid_d = 1'b1;
      end
    end else if (take) begin
      // A key replayed from RESULT keeps key_ready low for its processing cycle.
      hold = reproc;
      if (code == K_ILLEGAL) begin
        key_err_d = 1'b1;
      end else if (code == K_CLEAR) begin
        op_rst_d       = 1'b1;
        result_valid_d = 1'b0;
        ndig_d         = '0;
        state_d        = SIGN1;
      end else begin
        case (state_q)
          RESULT: begin
            op_rst_d       = 1'b1;
            result_valid_d = 1'b0;
            ndig_d         = '0;
            state_d        = SIGN1;
            pend_d         = PEND_REPROC;
            pend_code_d    = code;
          end
          SIGN1, SIGN2: begin
            if (is_sign) begin
              op_sel_d  = 1'b1;
              op_data_d = code;
              ndig_d    = '0;
              state_d   = (state_q == SIGN1) ? DIG1 : DIG2;
            end else if (is_dig) begin
              op_sel_d    = 1'b1;
              op_data_d   = K_PLUS;
              pend_d      = PEND_FWD;
              pend_code_d = code;
              ndig_d      = 2'd1;
              state_d     = (state_q == SIGN1) ? DIG1 : DIG2;
            end else begin
              key_err_d = 1'b1;
            end
          end
          DIG1, DIG2: begin
            if (is_dig) begin
              op_sel_d  = 1'b1;
              op_data_d = code;
              ndig_d    = ndig_q + 2'd1;
              if (ndig_q == 2'd2) begin
                if (state_q == DIG1) begin
                  state_d = OPER;
                end else begin
                  pend_d      = PEND_FWD;
                  pend_code_d = K_ENTER;
                end
              end
            end else if ((code == K_ENTER) && (ndig_q != 2'd0)) begin
              op_sel_d  = 1'b1;
              op_data_d = code;
              state_d   = (state_q == DIG1) ? OPER : WAIT;
            end else begin
              key_err_d = 1'b1;
            end
          end
          OPER: begin
            if ((code >= K_PLUS) && (code <= K_TIMES)) begin
              op_sel_d  = 1'b1;
              op_data_d = code;
              state_d   = SIGN2;
            end else begin
              key_err_d = 1'b1;
            end
          end
          default: key_err_d = 1'b1;
        endcase
      end
    end

    key_ready_d = !hold && (pend_d == PEND_NONE) && (state_d != INIT) && (state_d != WAIT);
  end

  // State and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= INIT;
      pend_q         <= PEND_NONE;
      pend_code_q    <= '0;
      ndig_q         <= '0;
      key_ready_q    <= 1'b0;
      op_sel_q       <= 1'b0;
      op_data_q      <= '0;
      op_rst_q       <= 1'b0;
      result_valid_q <= 1'b0;
      key_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      pend_code_q    <= pend_code_d;
      ndig_q         <= ndig_d;
      key_ready_q    <= key_ready_d;
      op_sel_q       <= op_sel_d;
      op_data_q      <= op_data_d;
      op_rst_q       <= op_rst_d;
      result_valid_q <= result_valid_d;
      key_err_q      <= key_err_d;
    end
  end

  assign key_ready    = key_ready_q;
  assign op_sel       = op_sel_q;
  assign op_data      = {7'd0, op_data_q};
  assign op_rst       = op_rst_q;
  assign result_valid = result_valid_q;
  assign key_err      = key_err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed vector table, hand-timed corner
// sequences, and random keys checked against a grammar-level reference model.
module tb_calc_key_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        op_sel;
  logic [10:0] op_data;
  logic        op_rst;
  logic        result_valid;
  logic        key_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned overlap = 0;

  always #5 clk = ~clk;

  calc_key_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .op_sel       (op_sel),
    .op_data      (op_data),
    .op_rst       (op_rst),
    .result_valid (result_valid),
    .key_err      (key_err)
  );

  // op_sel and op_rst must never coincide.
  always @(negedge clk) if (rst && op_sel && op_rst) overlap++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model (grammar level) ----------------
  bit          m_sign [2];
  bit          m_end  [2];
  int          m_dig  [2];
  bit          m_op;
  bit          m_rv;
  logic [10:0] exp_q [$];
  int          exp_err, exp_rst;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sign[i] = 0; m_end[i] = 0; m_dig[i] = 0;
    end
    m_op = 0;
    m_rv = 0;
  endtask

  task automatic model_key(input logic [3:0] c);
    int k;
    exp_q.delete();
    exp_err = 0;
    exp_rst = 0;
    if (c == 4'd15) begin exp_err = 1; return; end
    if (c == 4'd13) begin exp_rst = 1; model_reset(); return; end
    if (m_rv) begin exp_rst = 1; model_reset(); end
    k = m_op ? 1 : 0;
    if (!m_op && m_end[0]) begin
      if (c >= 4'd10 && c <= 4'd12) begin exp_q.push_back(11'(c)); m_op = 1; end
      else exp_err = 1;
    end else if (!m_sign[k]) begin
      if (c == 4'd10 || c == 4'd11) begin
        exp_q.push_back(11'(c)); m_sign[k] = 1;
      end else if (c <= 4'd9) begin
        exp_q.push_back(11'd10); exp_q.push_back(11'(c));
        m_sign[k] = 1; m_dig[k] = 1;
      end else exp_err = 1;
    end else begin
      if (c <= 4'd9) begin
        exp_q.push_back(11'(c));
        m_dig[k]++;
        if (m_dig[k] == 3) begin
          m_end[k] = 1;
          if (k == 1) exp_q.push_back(11'd14);
        end
      end else if (c == 4'd14 && m_dig[k] > 0) begin
        exp_q.push_back(11'd14); m_end[k] = 1;
      end else exp_err = 1;
    end
    m_rv = m_end[1];
  endtask

  // ---------------- drivers ----------------
  logic [10:0] got_q [$];
  int          got_err, got_rst;
  logic        got_rv;

  // Present a key, hold it until accepted, then gather every output event
  // up to and including the cycle in which key_ready returns.
  task automatic send_key(input logic [3:0] c);
    bit acc;
    int guard;
    got_q.delete();
    got_err = 0;
    got_rst = 0;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    guard = 0;
    acc = key_ready;
    while (!acc && guard < 20) begin
      @(negedge clk); acc = key_ready; guard++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept: key %0d never accepted (key_ready=%0d, required 1)", c, key_ready);
      key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    guard = 0;
    forever begin
      if (op_sel) got_q.push_back(op_data);
      if (key_err) got_err++;
      if (op_rst) got_rst++;
      if (key_ready || guard >= 10) break;
      @(negedge clk);
      guard++;
    end
    got_rv = result_valid;
    check("ready_return", key_ready, 1);
  endtask

  task automatic drive_accept(input logic [3:0] c);
    int guard = 0;
    @(negedge clk);
    while (!key_ready && guard < 20) begin @(negedge clk); guard++; end
    check("ready_before_key", key_ready, 1);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    key_code  = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] key;
    int         n;
    logic [3:0] c0;
    logic [3:0] c1;
    int         err;
    int         rs;
    int         rv;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [3:0] c;
    int         r;

    // key, #strobes, code0, code1, key_err, op_rst, result_valid after
    tbl.push_back('{4'd14, 0, 4'd0,  4'd0,  1, 0, 0}); // enter in SIGN1
    tbl.push_back('{4'd1,  2, 4'd10, 4'd1,  0, 0, 0});
    tbl.push_back('{4'd2,  1, 4'd2,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd15, 0, 4'd0,  4'd0,  1, 0, 0}); // illegal in DIG1
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd7,  0, 4'd0,  4'd0,  1, 0, 0}); // digit in OPER
    tbl.push_back('{4'd10, 1, 4'd10, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd3,  2, 4'd10, 4'd3,  0, 0, 0});
    tbl.push_back('{4'd4,  1, 4'd4,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 1}); // 12+34
    tbl.push_back('{4'd15, 0, 4'd0,  4'd0,  1, 0, 1}); // illegal in RESULT
    tbl.push_back('{4'd11, 1, 4'd11, 4'd0,  0, 1, 0}); // new calc from RESULT
    tbl.push_back('{4'd12, 0, 4'd0,  4'd0,  1, 0, 0}); // times with ndig=0
    tbl.push_back('{4'd14, 0, 4'd0,  4'd0,  1, 0, 0}); // enter with ndig=0
    tbl.push_back('{4'd5,  1, 4'd5,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd12, 1, 4'd12, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd3,  2, 4'd10, 4'd3,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 1}); // -5*3
    tbl.push_back('{4'd9,  2, 4'd10, 4'd9,  0, 1, 0});
    tbl.push_back('{4'd9,  1, 4'd9,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd9,  1, 4'd9,  4'd0,  0, 0, 0}); // 3rd digit: straight to OPER
    tbl.push_back('{4'd10, 1, 4'd10, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd9,  2, 4'd10, 4'd9,  0, 0, 0});
    tbl.push_back('{4'd9,  1, 4'd9,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd9,  2, 4'd9,  4'd14, 0, 0, 1}); // auto enter
    tbl.push_back('{4'd13, 0, 4'd0,  4'd0,  0, 1, 0}); // clear in RESULT
    tbl.push_back('{4'd10, 1, 4'd10, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd6,  1, 4'd6,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd12, 1, 4'd12, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd11, 1, 4'd11, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd2,  1, 4'd2,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd13, 0, 4'd0,  4'd0,  0, 1, 0}); // clear mid operand 2
    tbl.push_back('{4'd2,  2, 4'd10, 4'd2,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd11, 1, 4'd11, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd1,  2, 4'd10, 4'd1,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 1});
    tbl.push_back('{4'd12, 0, 4'd0,  4'd0,  1, 1, 0}); // RESULT -> reset -> rejected
    tbl.push_back('{4'd4,  2, 4'd10, 4'd4,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd10, 1, 4'd10, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd11, 1, 4'd11, 4'd0,  0, 0, 0});
    tbl.push_back('{4'd7,  1, 4'd7,  4'd0,  0, 0, 0});
    tbl.push_back('{4'd14, 1, 4'd14, 4'd0,  0, 0, 1});
    tbl.push_back('{4'd4,  2, 4'd10, 4'd4,  0, 1, 0}); // key 4 from RESULT

    // Reset values and the INIT pulse.
    rst = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    @(negedge clk); @(negedge clk);
    check("rst_key_ready", key_ready, 0);
    check("rst_op_sel", op_sel, 0);
    check("rst_op_data", op_data, 0);
    check("rst_op_rst", op_rst, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_key_err", key_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("init_op_rst", op_rst, 1);
    check("init_ready_low", key_ready, 0);
    @(negedge clk);
    check("init_op_rst_end", op_rst, 0);
    check("init_ready_high", key_ready, 1);

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      send_key(tbl[i].key);
      check($sformatf("tbl%0d_nstrobe", i), got_q.size(), tbl[i].n);
      if (tbl[i].n > 0)
        check($sformatf("tbl%0d_code0", i), (got_q.size() > 0) ? got_q[0] : 11'h7FF, 32'(tbl[i].c0));
      if (tbl[i].n > 1)
        check($sformatf("tbl%0d_code1", i), (got_q.size() > 1) ? got_q[1] : 11'h7FF, 32'(tbl[i].c1));
      check($sformatf("tbl%0d_err", i), got_err, tbl[i].err);
      check($sformatf("tbl%0d_oprst", i), got_rst, tbl[i].rs);
      check($sformatf("tbl%0d_rv", i), got_rv, tbl[i].rv);
    end

    // Cycle-exact corner sequences.
    do_reset();
    drive_accept(4'd5);                              // implicit 10 before digit
    check("imp10_sel", op_sel, 1);
    check("imp10_data", op_data, 10);
    check("imp10_ready", key_ready, 0);
    @(negedge clk);
    check("imp10_dig_sel", op_sel, 1);
    check("imp10_dig_data", op_data, 5);
    check("imp10_dig_ready", key_ready, 1);
    drive_accept(4'd14);
    drive_accept(4'd12);
    drive_accept(4'd1);
    @(negedge clk);
    drive_accept(4'd14);                             // final enter, cycle M
    check("fin_sel", op_sel, 1);
    check("fin_data", op_data, 14);
    check("fin_ready_m", key_ready, 0);
    check("fin_rv_m", result_valid, 0);
    @(negedge clk);
    check("fin_ready_m1", key_ready, 0);
    check("fin_rv_m1", result_valid, 0);
    @(negedge clk);
    check("fin_rv_m2", result_valid, 1);
    check("fin_ready_m2", key_ready, 1);
    drive_accept(4'd11);                             // key from RESULT
    check("res_oprst", op_rst, 1);
    check("res_sel_n1", op_sel, 0);
    check("res_ready_n1", key_ready, 0);
    check("res_rv_n1", result_valid, 0);
    @(negedge clk);
    check("res_sel_n2", op_sel, 1);
    check("res_data_n2", op_data, 11);
    check("res_ready_n2", key_ready, 0);
    check("res_oprst_n2", op_rst, 0);
    @(negedge clk);
    check("res_ready_n3", key_ready, 1);
    drive_accept(4'd3);
    check("mid_sel_before", op_sel, 1);
    #1 rst = 1'b0;                                   // asynchronous reset mid-sequence
    #1;
    check("async_sel", op_sel, 0);
    check("async_data", op_data, 0);
    check("async_ready", key_ready, 0);
    check("async_oprst", op_rst, 0);
    check("async_rv", result_valid, 0);
    check("async_err", key_err, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("reinit_op_rst", op_rst, 1);
    check("reinit_ready", key_ready, 0);
    @(negedge clk);
    check("reinit_op_rst_end", op_rst, 0);
    check("reinit_ready_high", key_ready, 1);

    // Random keys against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      c = 4'($urandom_range(0, 9));
      else if (r < 80) c = 4'($urandom_range(10, 12));
      else if (r < 93) c = 4'd14;
      else if (r < 97) c = 4'd13;
      else             c = 4'd15;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_key(c);
      send_key(c);
      check($sformatf("rnd%0d_nstrobe", n), got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size(); j++)
        check($sformatf("rnd%0d_code%0d", n, j), (j < got_q.size()) ? got_q[j] : 11'h7FF, exp_q[j]);
      check($sformatf("rnd%0d_err", n), got_err, exp_err);
      check($sformatf("rnd%0d_oprst", n), got_rst, exp_rst);
      check($sformatf("rnd%0d_rv", n), got_rv, m_rv);
    end

    check("sel_rst_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
